// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 11-bit frame, then ACK check.
// Lines are open-drain; *_oe = 1 pulls the line low. Result reported as ack_ok/err alongside a done pulse.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned RTS_CYCLES     = 500,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, DONE} state_t;

  logic          clk_meta, clk_sync, data_meta, data_sync;
  logic          filt_clk, fall, filt_flip;
  logic [FW-1:0] filt_cnt;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [8:0]  shreg, shreg_nxt;
  logic        ready_nxt, done_nxt, ack_nxt, err_nxt, clk_oe_nxt, data_oe_nxt;

  // Idle bus level is high, so synchronizers reset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign filt_flip = (clk_sync != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));

  // Filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= filt_flip && filt_clk;
      if (filt_flip) begin
        filt_clk <= clk_sync;
        filt_cnt <= '0;
      end else if (clk_sync != filt_clk) begin
        filt_cnt <= filt_cnt + FW'(1);
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 32'd0;
      bit_cnt     <= 4'd0;
      shreg       <= 9'd0;
      tx_ready    <= 1'b1;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err         <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shreg       <= shreg_nxt;
      tx_ready    <= ready_nxt;
      done        <= done_nxt;
      ack_ok      <= ack_nxt;
      err         <= err_nxt;
      ps2_clk_oe  <= clk_oe_nxt;
      ps2_data_oe <= data_oe_nxt;
    end
  end

  assign busy = ~tx_ready;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    done_nxt    = 1'b0;
    ack_nxt     = ack_ok;
    err_nxt     = err;
    clk_oe_nxt  = 1'b0;
    data_oe_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_nxt   = INHIBIT;
          clk_oe_nxt  = 1'b1;
          cnt_nxt     = 32'd0;
          bit_cnt_nxt = 4'd0;
          shreg_nxt   = {~^tx_data, tx_data};
          ack_nxt     = 1'b0;
          err_nxt     = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      INHIBIT: begin
        clk_oe_nxt = 1'b1;
        if (cnt == INHIBIT_CYCLES - 32'd1) begin
          state_nxt   = RTS;
          cnt_nxt     = 32'd0;
          data_oe_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      RTS: begin
        data_oe_nxt = 1'b1;
        if (cnt == RTS_CYCLES - 32'd1) begin
          state_nxt = SEND;
          cnt_nxt   = 32'd0;
        end else begin
          clk_oe_nxt = 1'b1;
          cnt_nxt    = cnt + 32'd1;
        end
      end
      SEND, ACK, WAIT_IDLE: begin
        data_oe_nxt = ps2_data_oe;
        if (cnt == TIMEOUT_CYCLES - 32'd1) begin
          state_nxt   = DONE;
          data_oe_nxt = 1'b0;
          done_nxt    = 1'b1;
          ack_nxt     = 1'b0;
          err_nxt     = 1'b1;
        end else begin
          cnt_nxt = cnt + 32'd1;
          // Shift register refills with 1s, so the tenth fall naturally releases DATA as the stop bit.
          if (state == SEND) begin
            if (fall) begin
              bit_cnt_nxt = bit_cnt + 4'd1;
              data_oe_nxt = ~shreg[0];
              shreg_nxt   = {1'b1, shreg[8:1]};
              if (bit_cnt == 4'd9) begin
                state_nxt   = ACK;
                data_oe_nxt = 1'b0;
              end else begin
                state_nxt = SEND;
              end
            end else begin
              state_nxt = SEND;
            end
          end else if (state == ACK) begin
            data_oe_nxt = 1'b0;
            if (fall) begin
              ack_nxt   = ~data_sync;
              err_nxt   = data_sync;
              state_nxt = WAIT_IDLE;
            end else begin
              state_nxt = ACK;
            end
          end else begin
            data_oe_nxt = 1'b0;
            if (filt_clk && data_sync) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = WAIT_IDLE;
            end
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    ready_nxt = (state_nxt == IDLE);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx: a device model clocks frames while a cycle-level model checks outputs.
module tb_ps2_host_tx;
  localparam int I  = 40;
  localparam int R  = 10;
  localparam int TO = 3000;
  localparam int FL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ack_ok, err, ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch_low = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(I), .RTS_CYCLES(R), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .ack_ok(ack_ok), .err(err), .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int   n_pass = 0, n_total = 0;
  bit   chk_en = 1'b0;
  bit   m_active = 1'b0, m_fin = 1'b0, m_timeout = 1'b0, m_exp_ack = 1'b0;
  bit   m_last_ack = 1'b0, m_last_err = 1'b0, dev_fin = 1'b0;
  int   m_j = 0, m_fin_wait = 0;
  logic [7:0] m_data = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  function automatic bit odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) == 0;
  endfunction

  // Frame timeline model: cycles since accept, driven purely by bench-visible inputs.
  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_fin = 1'b0; m_last_ack = 1'b0; m_last_err = 1'b0;
    end else if (m_fin) begin
      m_active = 1'b0; m_fin = 1'b0;
    end else if (!m_active && tx_valid) begin
      m_active = 1'b1; m_j = 0; m_data = tx_data; m_fin_wait = 0;
      m_last_ack = 1'b0; m_last_err = 1'b0; dev_fin = 1'b0;
    end else if (m_active) begin
      m_j++;
      if (dev_fin) m_fin_wait++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("tx_ready", tx_ready, !m_active);
      chk1("busy", busy, m_active);
      if (!m_active) begin
        chk1("idle_clk_oe", ps2_clk_oe, 1'b0);
        chk1("idle_data_oe", ps2_data_oe, 1'b0);
        chk1("idle_done", done, 1'b0);
        chk1("hold_ack_ok", ack_ok, m_last_ack);
        chk1("hold_err", err, m_last_err);
      end else if (m_j < I + R) begin
        chk1("inhibit_clk_oe", ps2_clk_oe, 1'b1);
        chk1("rts_data_oe", ps2_data_oe, m_j >= I);
        chk1("early_done", done, 1'b0);
        chk1("cleared_ack_ok", ack_ok, 1'b0);
        chk1("cleared_err", err, 1'b0);
      end else begin
        chk1("released_clk_oe", ps2_clk_oe, 1'b0);
        if (done) begin
          chk1("done_data_oe", ps2_data_oe, 1'b0);
          chk1("done_ack_ok", ack_ok, m_exp_ack);
          chk1("done_err", err, !m_exp_ack);
          if (m_timeout) chk("timeout_cycle", m_j, I + R + TO);
          else chk1("done_after_device", dev_fin, 1'b1);
          m_last_ack = m_exp_ack; m_last_err = !m_exp_ack; m_fin = 1'b1;
        end else if (m_timeout && m_j >= I + R + TO) begin
          chk1("timeout_done_missing", done, 1'b1);
        end else if (!m_timeout && m_fin_wait > 40) begin
          chk1("done_missing", done, 1'b1);
        end
      end
    end
  end

  task automatic start_frame(input logic [7:0] d, input bit exp_ack, input bit tmo);
    int w = 0;
    while (tx_ready !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    m_exp_ack = exp_ack; m_timeout = tmo;
    tx_data = d; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_data = 8'($urandom);
  endtask

  // Device side: after CLK release, generate falls; sample DATA just before each rising edge.
  task automatic dev_frame(input bit do_ack, input int hp, input int abort_after,
                           input int glitch_after, output logic [9:0] got);
    int w = 0;
    got = 10'd0;
    while (!(m_active && m_j >= I + R) && w < 2000) begin @(posedge clk); #1; w++; end
    if (w >= 2000) begin chk1("release_wait", 1'b0, 1'b1); return; end
    repeat (4 * FL) @(posedge clk);
    #1;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      if (k == 11) dev_data_low = do_ack;
      repeat (hp) @(posedge clk);
      #1;
      if (k == abort_after) begin dev_clk_low = 1'b0; return; end
      if (k <= 10) got[k-1] = ps2_data_in;
      dev_clk_low = 1'b0;
      if (k == 11) begin dev_data_low = 1'b0; dev_fin = 1'b1; end
      if (k == glitch_after) begin
        repeat (hp / 2) @(posedge clk);
        #1 glitch_low = 1'b1;
        repeat (3) @(posedge clk);
        #1 glitch_low = 1'b0;
        repeat (hp - hp / 2 - 3) @(posedge clk);
      end else begin
        repeat (hp) @(posedge clk);
      end
      #1;
    end
  endtask

  task automatic wait_end(input int bound);
    int w = 0;
    while (m_active && w < bound) begin @(posedge clk); #1; w++; end
    chk1("frame_end", m_active, 1'b0);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input int hp, input int glitch,
                           output logic [9:0] got);
    start_frame(d, ack, 1'b0);
    dev_frame(ack, hp, 0, glitch, got);
    chk("bits_vs_model", 32'(got), 32'({1'b1, odd_par(m_data), m_data}));
    wait_end(200);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] got;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_tx_ready", tx_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ack_ok", ack_ok, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk1("rst_data_oe", ps2_data_oe, 1'b0);
    @(posedge clk); #1 rst = 1'b0; chk_en = 1'b1;

    // 0xED with ACK
    run_frame(8'hED, 1'b1, 30, 0, got);
    chk("ed_bits", 32'(got), 32'h3ED);
    @(negedge clk);
    chk1("ed_ack_ok", ack_ok, 1'b1);
    chk1("ed_err", err, 1'b0);

    // 0x00, device leaves DATA high -> NACK
    run_frame(8'h00, 1'b0, 27, 0, got);
    chk("zero_bits", 32'(got), 32'h300);
    @(negedge clk);
    chk1("nack_err", err, 1'b1);

    // device never clocks -> timeout
    start_frame(8'hA5, 1'b0, 1'b1);
    wait_end(I + R + TO + 100);
    @(negedge clk);
    chk1("timeout_err", err, 1'b1);

    // reset mid-frame after fall 4, then a clean 0xFF frame
    start_frame(8'h5A, 1'b1, 1'b0);
    dev_frame(1'b1, 30, 4, 0, got);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("abort_clk_oe", ps2_clk_oe, 1'b0);
    chk1("abort_data_oe", ps2_data_oe, 1'b0);
    chk1("abort_tx_ready", tx_ready, 1'b1);
    repeat (60) @(posedge clk);
    #1;
    run_frame(8'hFF, 1'b1, 30, 0, got);
    chk("ff_bits", 32'(got), 32'h3FF);

    // glitch on CLK during SEND plus tx_valid pulses while busy
    start_frame(8'hED, 1'b1, 1'b0);
    fork
      dev_frame(1'b1, 32, 0, 3, got);
      begin
        repeat (5) begin
          repeat ($urandom_range(20, 60)) @(posedge clk);
          #1 tx_valid = 1'b1; tx_data = 8'($urandom);
          @(posedge clk);
          #1 tx_valid = 1'b0;
        end
      end
    join
    chk("glitch_bits", 32'(got), 32'h3ED);
    wait_end(200);

    // randomized frames
    for (int n = 0; n < 6; n++) begin
      logic [7:0] d;
      bit         a;
      d = 8'($urandom);
      a = bit'($urandom_range(0, 1));
      run_frame(d, a, $urandom_range(25, 40), 0, got);
    end

    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
